// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with parity check, sticky errors and a small FWFT receive FIFO
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_rx,
  input  logic                         rxd,
  input  logic                         parity_en,
  input  logic                         parity_odd,
  input  logic                         rd,
  input  logic                         clr_err,
  output logic [DATA_BITS-1:0]         d_out,
  output logic                         pe_out,
  output logic                         rs,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         frame_err,
  output logic                         overrun
);
  localparam int CNTW = $clog2(OVERSAMPLE);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);
  localparam logic [CNTW-1:0] HALF = CNTW'(OVERSAMPLE/2-1);
  localparam logic [CNTW-1:0] FULL = CNTW'(OVERSAMPLE-1);
  localparam logic [2:0]      LAST = 3'(DATA_BITS-1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

  state_t                 r_state, w_state_n;
  logic [1:0]             r_sync;
  logic [CNTW-1:0]        r_cnt, w_cnt_n;
  logic [2:0]             r_bit, w_bit_n;
  logic [DATA_BITS-1:0]   r_shift, w_shift_n;
  logic                   r_perr, w_perr_n;
  logic                   w_push, w_ferr_set;
  logic [DATA_BITS:0]     r_mem [DEPTH];
  logic [PW-1:0]          r_wp, r_rp;
  logic [CW-1:0]          r_count;
  logic                   r_ferr, r_ovr;
  logic                   w_rxd_s, w_smp, w_empty, w_full, w_pop, w_wr, w_ovr_set;

  assign w_rxd_s   = r_sync[1];
  assign w_smp     = r_cnt == '0;
  assign w_empty   = r_count == '0;
  assign w_full    = r_count == CW'(DEPTH);
  assign w_pop     = rd && !w_empty;
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;

  assign d_out     = w_empty ? '0 : r_mem[r_rp][DATA_BITS-1:0];
  assign pe_out    = w_empty ? 1'b0 : r_mem[r_rp][DATA_BITS];
  assign rs        = !w_empty;
  assign count     = r_count;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

  // Receive FSM next state: everything moves only on oversample ticks
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_bit_n    = r_bit;
    w_shift_n  = r_shift;
    w_perr_n   = r_perr;
    w_push     = 1'b0;
    w_ferr_set = 1'b0;
    if (en_rx) begin
      case (r_state)
        S_IDLE: if (!w_rxd_s) begin
          w_state_n = S_START;
          w_cnt_n   = HALF;
        end
        S_START: if (w_smp) begin
          w_state_n = w_rxd_s ? S_IDLE : S_DATA;
          w_cnt_n   = FULL;
          w_bit_n   = '0;
          w_perr_n  = 1'b0;
        end else w_cnt_n = r_cnt - CNTW'(1);
        S_DATA: if (w_smp) begin
          w_shift_n = {w_rxd_s, r_shift[DATA_BITS-1:1]};
          w_cnt_n   = FULL;
          w_bit_n   = r_bit + 3'd1;
          if (r_bit == LAST) w_state_n = parity_en ? S_PARITY : S_STOP;
        end else w_cnt_n = r_cnt - CNTW'(1);
        S_PARITY: if (w_smp) begin
          w_perr_n  = (^r_shift ^ w_rxd_s) != parity_odd;
          w_cnt_n   = FULL;
          w_state_n = S_STOP;
        end else w_cnt_n = r_cnt - CNTW'(1);
        S_STOP: if (w_smp) begin
          w_state_n  = w_rxd_s ? S_IDLE : S_WAIT;
          w_push     = w_rxd_s;
          w_ferr_set = !w_rxd_s;
        end else w_cnt_n = r_cnt - CNTW'(1);
        S_WAIT: if (w_rxd_s) w_state_n = S_IDLE;
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // Synchroniser, FSM registers, FIFO pointers/occupancy and sticky flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync  <= 2'b11;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rxd};
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_perr  <= w_perr_n;
      r_wp    <= w_wr ? r_wp + PW'(1) : r_wp;
      r_rp    <= w_pop ? r_rp + PW'(1) : r_rp;
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
      r_ferr  <= w_ferr_set ? 1'b1 : clr_err ? 1'b0 : r_ferr;
      r_ovr   <= w_ovr_set ? 1'b1 : clr_err ? 1'b0 : r_ovr;
    end
  end

  // FIFO storage; the parity tag is meaningless without parity so it is forced low
  always_ff @(posedge clk) begin
    if (rst && w_wr) r_mem[r_wp] <= {parity_en & r_perr, r_shift};
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames against the default build and a 5-bit build
module tb_uart_rx_fifo;
  logic clk = 0, rst = 0, en_rx = 0, rxd = 1, rxd5 = 1, rd = 0, rd5 = 0, clr_err = 0;
  logic parity_en = 0, parity_odd = 0;
  logic [7:0] d_out;
  logic [4:0] d_out5;
  logic [2:0] count, count5;
  logic pe_out, rs, frame_err, overrun, pe_out5, rs5, frame_err5, overrun5;
  logic [7:0] c3 = 8'hC3;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  uart_rx_fifo dut (
    .clk(clk), .rst(rst), .en_rx(en_rx), .rxd(rxd), .parity_en(parity_en),
    .parity_odd(parity_odd), .rd(rd), .clr_err(clr_err), .d_out(d_out),
    .pe_out(pe_out), .rs(rs), .count(count), .frame_err(frame_err), .overrun(overrun)
  );

  uart_rx_fifo #(.DATA_BITS(5)) dut5 (
    .clk(clk), .rst(rst), .en_rx(en_rx), .rxd(rxd5), .parity_en(parity_en),
    .parity_odd(parity_odd), .rd(rd5), .clr_err(clr_err), .d_out(d_out5),
    .pe_out(pe_out5), .rs(rs5), .count(count5), .frame_err(frame_err5), .overrun(overrun5)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input logic do_rd);
    repeat (3) @(posedge clk);
    #1 en_rx = 1;
    rd = do_rd;
    @(posedge clk);
    #1 en_rx = 0;
    rd = 0;
  endtask

  task automatic bit_time(input logic sel, input logic v, input logic rd_stop);
    if (sel) rxd5 = v; else rxd = v;
    for (int t = 0; t < 8; t++) tick(rd_stop && t == 4);
  endtask

  task automatic send(input logic sel, input int nb, input logic [7:0] d, input logic pen,
                      input logic pbit, input logic stop, input logic rd_stop);
    bit_time(sel, 0, 0);
    for (int i = 0; i < nb; i++) bit_time(sel, d[i], 0);
    if (pen) bit_time(sel, pbit, 0);
    bit_time(sel, stop, rd_stop);
  endtask

  task automatic pop;
    rd = 1;
    @(posedge clk);
    #1 rd = 0;
    @(negedge clk);
  endtask

  task automatic clear;
    clr_err = 1;
    @(posedge clk);
    #1 clr_err = 0;
    @(negedge clk);
  endtask

  task automatic bad_frame;
    send(0, 8, 8'h55, 0, 0, 0, 0);
    bit_time(0, 0, 0);
    bit_time(0, 0, 0);
    bit_time(0, 1, 0);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_rs", rs, 0);
    chk("rst_dout", d_out, 0);
    chk("rst_pe", pe_out, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1;

    send(0, 8, 8'hA5, 0, 0, 1, 0);
    @(negedge clk);
    chk("a5_dout", d_out, 8'hA5);
    chk("a5_pe", pe_out, 0);
    chk("a5_rs", rs, 1);
    chk("a5_count", count, 1);
    pop;
    chk("pop_rs", rs, 0);
    chk("pop_count", count, 0);
    chk("pop_dout", d_out, 0);

    parity_en = 1;
    send(0, 8, 8'h03, 1, 1, 1, 0);
    @(negedge clk);
    chk("par1_dout", d_out, 8'h03);
    chk("par1_pe", pe_out, 1);
    pop;
    send(0, 8, 8'h03, 1, 0, 1, 0);
    @(negedge clk);
    chk("par0_dout", d_out, 8'h03);
    chk("par0_pe", pe_out, 0);
    pop;
    parity_en = 0;

    bad_frame;
    chk("ferr_set", frame_err, 1);
    chk("ferr_count", count, 0);
    send(0, 8, 8'h12, 0, 0, 1, 0);
    @(negedge clk);
    chk("after_ferr_dout", d_out, 8'h12);
    pop;
    chk("ferr_held", frame_err, 1);
    clear;
    chk("ferr_clr", frame_err, 0);

    for (int i = 1; i <= 5; i++) send(0, 8, 8'(i), 0, 0, 1, 0);
    @(negedge clk);
    chk("ovr_set", overrun, 1);
    chk("ovr_count", count, 4);
    for (int i = 1; i <= 4; i++) begin
      chk("ovr_rd", d_out, i);
      pop;
    end
    chk("ovr_empty", count, 0);
    clear;
    chk("ovr_clr", overrun, 0);

    for (int i = 8'h11; i <= 8'h14; i++) send(0, 8, 8'(i), 0, 0, 1, 0);
    send(0, 8, 8'h15, 0, 0, 1, 1);
    @(negedge clk);
    chk("coin_ovr", overrun, 0);
    chk("coin_count", count, 4);
    for (int i = 8'h12; i <= 8'h15; i++) begin
      chk("coin_rd", d_out, i);
      pop;
    end

    rxd = 0;
    tick(0);
    tick(0);
    rxd = 1;
    for (int t = 0; t < 8; t++) tick(0);
    @(negedge clk);
    chk("glitch_count", count, 0);
    chk("glitch_ferr", frame_err, 0);
    send(0, 8, 8'h3C, 0, 0, 1, 0);
    @(negedge clk);
    chk("glitch_next", d_out, 8'h3C);
    chk("glitch_next_cnt", count, 1);
    pop;

    send(1, 5, 8'h1B, 0, 0, 1, 0);
    @(negedge clk);
    chk("db5_dout", d_out5, 5'h1B);
    chk("db5_count", count5, 1);
    chk("db5_other", count, 0);

    bad_frame;
    send(0, 8, 8'h77, 0, 0, 1, 0);
    @(negedge clk);
    chk("pre_rst_ferr", frame_err, 1);
    chk("pre_rst_count", count, 1);
    bit_time(0, 0, 0);
    for (int i = 0; i < 6; i++) bit_time(0, c3[i], 0);
    rst = 0;
    @(posedge clk);
    #1 rst = 1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rs", rs, 0);
    chk("mid_rst_dout", d_out, 0);
    chk("mid_rst_pe", pe_out, 0);
    chk("mid_rst_ferr", frame_err, 0);
    chk("mid_rst_db5", count5, 0);
    bit_time(0, c3[6], 0);
    bit_time(0, c3[7], 0);
    bit_time(0, 1, 0);
    @(negedge clk);
    chk("partial_none", count, 0);
    send(0, 8, 8'hC3, 0, 0, 1, 0);
    @(negedge clk);
    chk("c3_dout", d_out, 8'hC3);
    chk("c3_count", count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
